// File: rtl/vga_rx_timing_recovery.sv
// vga_rx_timing_recovery: rebuilds raster position from the sync edges alone,
// verifies that the stream keeps exact frame timing and re-presents each pixel.
//
// Ports:
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   hsync_in, vsync_in   raw syncs, polarity selected by SYNC_ACTIVE_LOW
//   rgb_in[5:0]          {R[1:0],G[1:0],B[1:0]}
//   locked               timing verified over LOCK_FRAMES clean frames
//   hpos, vpos, pix      recovered column/row and pixel, 3 cycles after pins
//   de                   pix is an active-area pixel and locked is set
//   frame_start          one-cycle pulse at pixel (0,0) of each locked frame
//   err_count            saturating count of lock losses
//   line_len             clocks between the last two hsync assertion edges
//
// Optional macro VGA_RX_CRC_EN adds frame_crc[15:0] and crc_valid: a
// CRC-16-CCITT over the pixels of each complete locked frame.

module vga_rx_timing_recovery #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned H_TOTAL         = 800,
    parameter int unsigned HSYNC_START     = 656,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned V_TOTAL         = 525,
    parameter int unsigned VSYNC_START     = 490,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [5:0]  rgb_in,
    output logic        locked,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        de,
    output logic [5:0]  pix,
    output logic        frame_start,
    output logic [7:0]  err_count,
    output logic [10:0] line_len
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam logic [9:0] HA_L   = 10'(H_ACTIVE);
    localparam logic [9:0] HMAX_L = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_L   = 10'(HSYNC_START);
    localparam logic [9:0] VA_L   = 10'(V_ACTIVE);
    localparam logic [9:0] VMAX_L = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_L   = 10'(VSYNC_START);
    localparam logic [7:0] LF_L   = 8'(LOCK_FRAMES);

    localparam int unsigned TMO_LINES = 2 * V_TOTAL;
    localparam int          LW        = $clog2(TMO_LINES + 1);
    localparam logic [LW-1:0] TMO_L   = LW'(TMO_LINES - 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Sync shift registers hold the normalised (1 = asserted) level:
    // [0] first flop, [1] synchronised sample, [2] previous sample.
    logic [2:0]    hs_q;
    logic [2:0]    vs_q;
    logic [5:0]    rgb1_q;
    logic [5:0]    rgb2_q;

    logic          h_edge;
    logic          v_edge;

    logic [9:0]    hcnt_q;
    logic [9:0]    hcnt_d;
    logic [9:0]    vcnt_q;
    logic [9:0]    vcnt_d;
    logic [9:0]    cur_h;
    logic [9:0]    cur_v;
    logic          h_wrap;

    logic [LW-1:0] lines_q;
    logic [LW-1:0] lines_d;
    logic          h_bad;
    logic          v_bad;
    logic          v_good;
    logic          tmo;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [7:0]    good_q;
    logic [7:0]    good_d;
    logic          err_inc;
    logic          locked_d;

    logic          locked_q;
    logic [9:0]    hpos_q;
    logic [9:0]    vpos_q;
    logic          de_q;
    logic [5:0]    pix_q;
    logic          fs_q;
    logic [7:0]    err_q;
    logic [10:0]   line_len_q;
    logic [10:0]   hdist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q   <= '0;
            vs_q   <= '0;
            rgb1_q <= '0;
            rgb2_q <= '0;
        end else begin
            hs_q   <= {hs_q[1:0], hsync_in ^ SYNC_ACTIVE_LOW};
            vs_q   <= {vs_q[1:0], vsync_in ^ SYNC_ACTIVE_LOW};
            rgb1_q <= rgb_in;
            rgb2_q <= rgb1_q;
        end
    end

    assign h_edge = hs_q[1] & ~hs_q[2];
    assign v_edge = vs_q[1] & ~vs_q[2];

    // cur_h/cur_v: position of the synchronised sample after any reload.
    always_comb begin
        cur_h  = h_edge ? HS_L : hcnt_q;
        cur_v  = v_edge ? VS_L : vcnt_q;
        h_wrap = (cur_h == HMAX_L);
        hcnt_d = h_wrap ? 10'd0 : cur_h + 10'd1;
        vcnt_d = cur_v;
        if (h_wrap) begin
            vcnt_d = (cur_v == VMAX_L) ? 10'd0 : cur_v + 10'd1;
        end
    end

    // Checks compare against the free-running counts before any reload.
    assign h_bad  = h_edge && (hcnt_q != HS_L);
    assign v_bad  = v_edge && (vcnt_q != VS_L);
    assign v_good = v_edge && (vcnt_q == VS_L);
    assign tmo    = h_wrap && !v_edge && (lines_q == TMO_L);

    always_comb begin
        lines_d = lines_q;
        if (state_q == ST_HUNT || v_edge) begin
            lines_d = '0;
        end else if (h_wrap) begin
            lines_d = lines_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_inc = 1'b0;
        unique case (1'b1)
            (state_q == ST_HUNT): begin
                if (v_edge) begin
                    good_d  = 8'd0;
                    state_d = ST_CHECK;
                end
            end
            (state_q == ST_CHECK): begin
                if (h_bad || v_bad || tmo) begin
                    state_d = ST_HUNT;
                end else if (v_good) begin
                    good_d = good_q + 8'd1;
                    if (good_q + 8'd1 >= LF_L) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            (state_q == ST_LOCKED): begin
                if (h_bad || v_bad || tmo) begin
                    state_d = ST_HUNT;
                    err_inc = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    assign locked_d = (state_d == ST_LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            lines_q <= '0;
            state_q <= ST_HUNT;
            good_q  <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            lines_q <= lines_d;
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q   <= 1'b0;
            hpos_q     <= '0;
            vpos_q     <= '0;
            de_q       <= 1'b0;
            pix_q      <= '0;
            fs_q       <= 1'b0;
            err_q      <= '0;
            line_len_q <= '0;
            hdist_q    <= '0;
        end else begin
            locked_q <= locked_d;
            hpos_q   <= cur_h;
            vpos_q   <= cur_v;
            pix_q    <= rgb2_q;
            de_q     <= locked_d && (cur_h < HA_L) && (cur_v < VA_L);
            fs_q     <= locked_d && (cur_h == 10'd0) && (cur_v == 10'd0);
            if (err_inc && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
            // hdist_q counts clocks since the last edge sample.
            if (h_edge) begin
                line_len_q <= hdist_q;
                hdist_q    <= 11'd1;
            end else if (hdist_q != 11'h7FF) begin
                hdist_q <= hdist_q + 11'd1;
            end
        end
    end

    assign locked      = locked_q;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign de          = de_q;
    assign pix         = pix_q;
    assign frame_start = fs_q;
    assign err_count   = err_q;
    assign line_len    = line_len_q;

`ifdef VGA_RX_CRC_EN
    // Six message bits per clock, pix[5] first.
    function automatic logic [15:0] crc_step6(input logic [15:0] c,
                                              input logic [5:0]  d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) begin
                r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    logic [15:0] crc_q;
    logic [15:0] crc_seed;
    logic [15:0] crc_nx;
    logic        crc_last;
    logic [15:0] frame_crc_q;
    logic        crc_valid_q;

    // Restarting at (0,0) discards anything left from an aborted frame.
    assign crc_seed = (hpos_q == 10'd0 && vpos_q == 10'd0) ? 16'hFFFF : crc_q;
    assign crc_nx   = crc_step6(crc_seed, pix_q);
    assign crc_last = (hpos_q == HA_L - 10'd1) && (vpos_q == VA_L - 10'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_valid_q <= 1'b0;
            if (de_q) begin
                crc_q <= crc_nx;
                if (crc_last) begin
                    frame_crc_q <= crc_nx;
                    crc_valid_q <= 1'b1;
                end
            end
        end
    end

    assign frame_crc = frame_crc_q;
    assign crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_vga_rx_timing_recovery.sv
// Directed bench for vga_rx_timing_recovery on a reduced raster
// (16x10 total, 8x6 active) so several frames fit in a short run.

module tb_vga_rx_timing_recovery;

    localparam int HA = 8;
    localparam int HT = 16;
    localparam int HS = 10;
    localparam int VA = 6;
    localparam int VT = 10;
    localparam int VS = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [5:0]  rgb_in = '0;
    logic        locked;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        de;
    logic [5:0]  pix;
    logic        frame_start;
    logic [7:0]  err_count;
    logic [10:0] line_len;
`ifdef VGA_RX_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
    bit          crc_seen;
    logic [15:0] crc_val;
`endif

    always #5 clk = ~clk;

    vga_rx_timing_recovery #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_START(HS),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VSYNC_START(VS),
        .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .locked(locked), .hpos(hpos), .vpos(vpos), .de(de), .pix(pix),
        .frame_start(frame_start), .err_count(err_count),
        .line_len(line_len)
`ifdef VGA_RX_CRC_EN
        , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    int gh, gv, cur_len, mode, fs_seen;
    bit vs_shift, vs_off, pixchk;
    int ph[3];
    int pv[3];
    logic [5:0] prgb[3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] rgbf(input int h, input int v, input int m);
        logic [9:0] hv;
        hv = 10'(h);
        if (m == 0) return hv[5:0];
        if (m == 1) return hv[5:0] ^ ((h == 2 && v == 1) ? 6'd1 : 6'd0);
        return 6'd0;
    endfunction

    function automatic logic [15:0] crc_model(input int m);
        logic [15:0] c;
        logic [5:0]  p;
        logic        fb;
        c = 16'hFFFF;
        for (int v = 0; v < VA; v++) begin
            for (int h = 0; h < HA; h++) begin
                p = rgbf(h, v, m);
                for (int b = 5; b >= 0; b--) begin
                    fb = c[15] ^ p[b];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
            end
        end
        return c;
    endfunction

    // One pixel clock: check outputs against the drive of 3 cycles ago,
    // then drive the next raster position.
    task automatic step();
        bit hs, vs;
        int vst;
        @(negedge clk);
        if (pixchk) begin
            chk("hpos", 32'(hpos), 32'(ph[2]));
            chk("vpos", 32'(vpos), 32'(pv[2]));
            chk("pix", 32'(pix), 32'(prgb[2]));
            chk("de", 32'(de), 32'(ph[2] < HA && pv[2] < VA));
            chk("frame_start", 32'(frame_start),
                32'(ph[2] == 0 && pv[2] == 0));
            if (frame_start && hpos == 10'd0 && vpos == 10'd0) fs_seen++;
        end
`ifdef VGA_RX_CRC_EN
        if (crc_valid) begin
            crc_seen = 1'b1;
            crc_val  = frame_crc;
        end
`endif
        vst = VS + (vs_shift ? 1 : 0);
        hs = (gh >= HS && gh < HS + 2);
        vs = !vs_off && gv >= vst && gv < vst + 2;
        hsync_in = ~hs;
        vsync_in = ~vs;
        rgb_in = rgbf(gh, gv, mode);
        ph[2] = ph[1]; pv[2] = pv[1]; prgb[2] = prgb[1];
        ph[1] = ph[0]; pv[1] = pv[0]; prgb[1] = prgb[0];
        ph[0] = gh;    pv[0] = gv;    prgb[0] = rgb_in;
        gh++;
        if (gh >= cur_len) begin
            gh = 0;
            cur_len = HT;
            gv = (gv + 1) % VT;
        end
    endtask

`ifdef VGA_RX_CRC_EN
    // Discard the first pulse (frame may mix modes), return the next one.
    task automatic get_crc(output logic [15:0] c);
        int w;
        bit ok;
        c = '0;
        ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            crc_seen = 1'b0;
            w = 0;
            while (!crc_seen && w < 400) begin
                step();
                w++;
            end
            if (!crc_seen) ok = 1'b0;
        end
        chk("crc_valid pulse", 32'(ok), 32'd1);
        c = crc_val;
    endtask
`endif

    typedef struct {
        int cycles;
        int act;
        bit shift;
        bit off;
        bit pchk;
        bit exp_lock;
        int exp_err;
        int exp_len;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl[NV];

    initial begin
        tbl[0]  = '{300,   0, 0, 0, 0, 0, 0, 16};
        tbl[1]  = '{200,   0, 0, 0, 0, 1, 0, 16};
        tbl[2]  = '{160,   0, 0, 0, 1, 1, 0, 16};
        tbl[3]  = '{32,    1, 0, 0, 0, 0, 1, 15};
        tbl[4]  = '{300,   0, 0, 0, 0, 0, 1, 16};
        tbl[5]  = '{200,   0, 0, 0, 0, 1, 1, 16};
        tbl[6]  = '{200,   0, 1, 0, 0, 0, 2, 16};
        tbl[7]  = '{600,   0, 1, 0, 0, 1, 2, 16};
        tbl[8]  = '{17000, 0, 0, 1, 0, 0, 3, 16};
        tbl[9]  = '{2000,  0, 0, 1, 0, 0, 3, 16};
        tbl[10] = '{800,   0, 0, 0, 0, 1, 3, 16};

        gh = 3; gv = 2; cur_len = HT; mode = 0;
        vs_shift = 0; vs_off = 0; pixchk = 0; fs_seen = 0;
        for (int i = 0; i < 3; i++) begin
            ph[i] = 0; pv[i] = 0; prgb[i] = '0;
        end

        repeat (3) @(negedge clk);
        chk("reset locked", 32'(locked), 32'd0);
        chk("reset de", 32'(de), 32'd0);
        chk("reset hpos", 32'(hpos), 32'd0);
        chk("reset vpos", 32'(vpos), 32'd0);
        chk("reset pix", 32'(pix), 32'd0);
        chk("reset frame_start", 32'(frame_start), 32'd0);
        chk("reset err_count", 32'(err_count), 32'd0);
        chk("reset line_len", 32'(line_len), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            vs_shift = tbl[i].shift;
            vs_off   = tbl[i].off;
            pixchk   = tbl[i].pchk;
            fs_seen  = 0;
            if (tbl[i].act == 1) begin
                int w;
                w = 0;
                while (!(gh == 0 && gv == 1) && w < 400) begin
                    step();
                    w++;
                end
                cur_len = HT - 1;
            end
            repeat (tbl[i].cycles) step();
            pixchk = 0;
            chk($sformatf("row%0d locked", i), 32'(locked),
                32'(tbl[i].exp_lock));
            chk($sformatf("row%0d err_count", i), 32'(err_count),
                32'(tbl[i].exp_err));
            chk($sformatf("row%0d line_len", i), 32'(line_len),
                32'(tbl[i].exp_len));
            if (tbl[i].pchk) chk("frame_start count", 32'(fs_seen), 32'd1);
        end

        // Mid-line reset pulse: outputs must clear before the next edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async locked", 32'(locked), 32'd0);
        chk("async de", 32'(de), 32'd0);
        chk("async hpos", 32'(hpos), 32'd0);
        chk("async vpos", 32'(vpos), 32'd0);
        chk("async pix", 32'(pix), 32'd0);
        chk("async frame_start", 32'(frame_start), 32'd0);
        chk("async err_count", 32'(err_count), 32'd0);
        chk("async line_len", 32'(line_len), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (800) step();
        chk("relock locked", 32'(locked), 32'd1);
        chk("relock err_count", 32'(err_count), 32'd0);
        chk("relock line_len", 32'(line_len), 32'd16);

`ifdef VGA_RX_CRC_EN
        begin
            logic [15:0] c0, c1, c2, c3;
            mode = 0;
            get_crc(c0);
            get_crc(c1);
            chk("crc repeat", 32'(c1), 32'(c0));
            chk("crc model ramp", 32'(c0), 32'(crc_model(0)));
            mode = 1;
            get_crc(c2);
            chk("crc flip differs", 32'(c2 != c0), 32'd1);
            chk("crc model flip", 32'(c2), 32'(crc_model(1)));
            mode = 2;
            get_crc(c3);
            chk("crc model zero", 32'(c3), 32'(crc_model(2)));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
